// File: rtl/seg7_scan_if.sv
// Bus between a datapath and the 7-segment scan driver: display data and
// control flow toward the driver, segment/anode pins flow back out.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_en;
  logic                    blank_lz;
  logic                    load;
  logic [7:0]              seg;
  logic [NUM_DIGITS-1:0]   an;
  logic [2:0]              digit_idx;

  // Datapath side: supplies display data, observes the pins
  modport master (
    output value, dp_in, blink_en, blank_lz, load,
    input  seg, an, digit_idx
  );

  // Driver side: consumes display data, drives the pins
  modport slave (
    input  value, dp_in, blink_en, blank_lz, load,
    output seg, an, digit_idx
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver.
// One digit is lit per refresh slot; each slot opens with a ghost interval
// with every anode off so the shared segment bus can settle between digits.
// Display data is held in shadow registers captured on the load strobe.
// Blanking (leading-zero or blink) darkens the segments but keeps the anode
// scanning so the refresh duty cycle stays uniform across digits.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GHOST_CYC    = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_if.slave   bus
);

  localparam int PW = (REFRESH_DIV > 1)  ? $clog2(REFRESH_DIV)  : 1;
  localparam int DW = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  // One extra bit so the ghost limit never truncates against the counter
  localparam logic [PW:0]   GHOST_LIM  = (PW + 1)'(GHOST_CYC);

  // Active-low glyph for one hex nibble, bit order g..a
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h18;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      4'hF:    g = 7'h0E;
      default: g = 7'h7F;
    endcase
    return g;
  endfunction

  // Scan timing state
  logic [PW-1:0] presc_r;
  logic [DW-1:0] digit_r;
  logic [FW-1:0] frame_r;
  logic          phase_r;

  // Shadowed display data
  logic [4*NUM_DIGITS-1:0] value_sh_r;
  logic [NUM_DIGITS-1:0]   dp_sh_r;
  logic [NUM_DIGITS-1:0]   blink_sh_r;

  // Registered pin drivers
  logic [7:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;
  logic [2:0]            idx_r;

  // Combinational decode of the digit currently selected
  logic                  presc_wrap_s;
  logic                  digit_wrap_s;
  logic                  frame_wrap_s;
  logic                  ghost_s;
  logic                  zero_run_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_blink_s;
  logic                  cur_lz_s;
  logic                  blank_s;
  logic [NUM_DIGITS-1:0] an_sel_s;
  logic [7:0]            seg_next_s;
  logic [NUM_DIGITS-1:0] an_next_s;

  // Wrap conditions of the cascaded slot / digit / frame counters
  always_comb begin
    presc_wrap_s = (presc_r == PRESC_LAST);
    digit_wrap_s = presc_wrap_s && (digit_r == DIGIT_LAST);
    frame_wrap_s = digit_wrap_s && (frame_r == FRAME_LAST);
    ghost_s      = ({1'b0, presc_r} < GHOST_LIM);
  end

  // Slot prescaler: counts clk cycles within one digit slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= {PW{1'b0}};
    end else if (presc_wrap_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Digit pointer: advances once per slot, wrapping after the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= {DW{1'b0}};
    end else if (digit_wrap_s) begin
      digit_r <= {DW{1'b0}};
    end else if (presc_wrap_s) begin
      digit_r <= digit_r + DW'(1);
    end else begin
      digit_r <= digit_r;
    end
  end

  // Frame counter and blink phase: phase flips every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_r <= {FW{1'b0}};
      phase_r <= 1'b0;
    end else if (frame_wrap_s) begin
      frame_r <= {FW{1'b0}};
      phase_r <= ~phase_r;
    end else if (digit_wrap_s) begin
      frame_r <= frame_r + FW'(1);
      phase_r <= phase_r;
    end else begin
      frame_r <= frame_r;
      phase_r <= phase_r;
    end
  end

  // Shadow registers: capture display data only on the load strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_sh_r <= {(4*NUM_DIGITS){1'b0}};
      dp_sh_r    <= {NUM_DIGITS{1'b0}};
      blink_sh_r <= {NUM_DIGITS{1'b0}};
    end else if (bus.load) begin
      value_sh_r <= bus.value;
      dp_sh_r    <= bus.dp_in;
      blink_sh_r <= bus.blink_en;
    end else begin
      value_sh_r <= value_sh_r;
      dp_sh_r    <= dp_sh_r;
      blink_sh_r <= blink_sh_r;
    end
  end

  // Select the scanned digit, evaluate blanking and build next pin values.
  // The loop walks from the most significant digit down so zero_run_s tells
  // whether every nibble from the top down to digit i is zero.
  always_comb begin
    zero_run_s  = 1'b1;
    cur_nib_s   = 4'h0;
    cur_dp_s    = 1'b0;
    cur_blink_s = 1'b0;
    cur_lz_s    = 1'b0;
    an_sel_s    = {NUM_DIGITS{1'b1}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (value_sh_r[4*i +: 4] == 4'h0);
      if (digit_r == DW'(i)) begin
        cur_nib_s   = value_sh_r[4*i +: 4];
        cur_dp_s    = dp_sh_r[i];
        cur_blink_s = blink_sh_r[i];
        cur_lz_s    = (i > 0) && bus.blank_lz && zero_run_s;
        an_sel_s[i] = 1'b0;
      end else begin
        an_sel_s[i] = 1'b1;
      end
    end
    blank_s    = cur_lz_s || (phase_r && cur_blink_s);
    seg_next_s = {~(cur_dp_s && !blank_s), blank_s ? 7'h7F : hex_glyph(cur_nib_s)};
    an_next_s  = ghost_s ? {NUM_DIGITS{1'b1}} : an_sel_s;
  end

  // Output registers: segments, anodes and index update together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= 8'hFF;
      an_r  <= {NUM_DIGITS{1'b1}};
      idx_r <= 3'd0;
    end else begin
      seg_r <= seg_next_s;
      an_r  <= an_next_s;
      idx_r <= 3'(digit_r);
    end
  end

  assign bus.seg       = seg_r;
  assign bus.an        = an_r;
  assign bus.digit_idx = idx_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model pushes
// the expected pins every clock edge, a checker pops and compares them on the
// falling edge. Directed spot checks cover the documented display patterns.
module tb_seg7_scan_driver;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(
    .NUM_DIGITS(N), .REFRESH_DIV(4), .GHOST_CYC(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic [2:0] idx;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Single comparison point for the whole bench
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: expected pins after each edge, from time since reset
  int         t_m   = 0;
  logic [15:0] val_m = 16'h0;
  logic [3:0]  dp_m  = 4'h0;
  logic [3:0]  bl_m  = 4'h0;
  always @(posedge clk) begin : model
    exp_t       e;
    int         presc;
    int         d;
    int         frames;
    logic       ph;
    logic       blank;
    logic       dpl;
    logic [3:0] nib;
    logic [3:0] one;
    one = 4'b0001;
    if (!rst_n) begin
      t_m   = 0;
      val_m = 16'h0;
      dp_m  = 4'h0;
      bl_m  = 4'h0;
      e.seg = 8'hFF;
      e.an  = 4'hF;
      e.idx = 3'd0;
    end else begin
      presc  = t_m % 4;
      d      = (t_m / 4) % 4;
      frames = t_m / 16;
      ph     = ((frames / 2) % 2) == 1;
      nib    = 4'(val_m >> (4 * d));
      blank  = ph && bl_m[d];
      if (d > 0 && bus.blank_lz && ((val_m >> (4 * d)) == 16'h0)) blank = 1'b1;
      dpl    = dp_m[d] && !blank;
      e.seg  = {~dpl, blank ? 7'h7F : glyph_tab[nib]};
      e.an   = (presc < 1) ? 4'hF : ~(one << d);
      e.idx  = 3'(d);
      t_m++;
      if (bus.load) begin
        val_m = bus.value;
        dp_m  = bus.dp_in;
        bl_m  = bus.blink_en;
      end
    end
    exp_q.push_back(e);
  end

  // An asynchronous reset overrides whatever the last edge predicted
  always @(negedge rst_n) begin
    exp_t e;
    if ($time > 0) begin
      e.seg = 8'hFF;
      e.an  = 4'hF;
      e.idx = 3'd0;
      exp_q.delete();
      exp_q.push_back(e);
    end
  end

  // Checker: compare DUT pins against the oldest prediction
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("seg", 32'(bus.seg), 32'(e.seg));
      chk("an", 32'(bus.an), 32'(e.an));
      chk("idx", 32'(bus.digit_idx), 32'(e.idx));
      chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
    end
  end

  // Advance n rising edges, then step clear of the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One-cycle load strobe; returns once the new data is on the pins
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    cyc(1);
    bus.value    = v;
    bus.dp_in    = dp;
    bus.blink_en = bl;
    bus.load     = 1'b1;
    cyc(1);
    bus.load = 1'b0;
    cyc(1);
  endtask

  // Bounded wait for a given anode pattern; a timeout is a failed comparison
  task automatic wait_an(input string tag, input logic [3:0] target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      #1;
      if (bus.an === target) hit = 1'b1;
    end
    chk({tag, "_seen"}, 32'(hit), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    bus.value    = 16'h0;
    bus.dp_in    = 4'h0;
    bus.blink_en = 4'h0;
    bus.blank_lz = 1'b0;
    bus.load     = 1'b0;

    // Reset release and first scan slot
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_ghost_an", 32'(bus.an), 32'hF);
    cyc(1);
    chk("rel_first_an", 32'(bus.an), 32'hE);
    chk("rel_first_idx", 32'(bus.digit_idx), 32'd0);

    // Reset asserted mid-slot blanks the pins at once
    cyc(5);
    rst_n = 1'b0;
    #1;
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_idx", 32'(bus.digit_idx), 32'd0);
    cyc(2);
    rst_n = 1'b1;

    // Plain hex with one decimal point
    bus.blank_lz = 1'b0;
    do_load(16'h12AF, 4'b0100, 4'b0000);
    wait_an("hex_d2", 4'b1011);
    chk("hex_d2_seg", 32'(bus.seg), 32'h24);
    wait_an("hex_d3", 4'b0111);
    chk("hex_d3_seg", 32'(bus.seg), 32'hF9);
    wait_an("hex_d0", 4'b1110);
    chk("hex_d0_seg", 32'(bus.seg), 32'h8E);
    wait_an("hex_d1", 4'b1101);
    chk("hex_d1_seg", 32'(bus.seg), 32'h88);
    cyc(16);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    do_load(16'h0070, 4'b0000, 4'b0000);
    wait_an("lz_d3", 4'b0111);
    chk("lz_d3_seg", 32'(bus.seg), 32'hFF);
    wait_an("lz_d2", 4'b1011);
    chk("lz_d2_seg", 32'(bus.seg), 32'hFF);
    wait_an("lz_d1", 4'b1101);
    chk("lz_d1_seg", 32'(bus.seg), 32'hF8);
    wait_an("lz_d0", 4'b1110);
    chk("lz_d0_seg", 32'(bus.seg), 32'hC0);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_an("lz0_d0", 4'b1110);
    chk("lz0_d0_seg", 32'(bus.seg), 32'hC0);
    wait_an("lz0_d1", 4'b1101);
    chk("lz0_d1_seg", 32'(bus.seg), 32'hFF);
    cyc(16);

    // Blink on digit 0 over several blink periods
    bus.blank_lz = 1'b0;
    do_load(16'h8888, 4'b0000, 4'b0001);
    cyc(80);

    // Load every cycle while scanning
    bus.blink_en = 4'b0000;
    for (int i = 0; i < 48; i++) begin
      cyc(1);
      bus.value = 16'(i * 37 + 5);
      bus.load  = 1'b1;
    end
    cyc(1);
    bus.load = 1'b0;

    // Glyph sweep on digit 0
    for (int n = 0; n < 16; n++) begin
      do_load(16'(n), 4'b0000, 4'b0000);
      wait_an($sformatf("sweep_%0h", n), 4'b1110);
      chk($sformatf("glyph_%0h", n), 32'(bus.seg[6:0]), 32'(glyph_tab[n]));
      chk($sformatf("glyph_dp_%0h", n), 32'(bus.seg[7]), 32'd1);
    end

    cyc(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
